hazard_forwarding_unit: RTL
===========================

Name: hazard_forwarding_unit

Overview:
- Producer of the bubble-select for the ID-stage control-signal multiplexer: drives that mux's selector high to turn the current ID instruction into a NOP.
- Tracks destination-register info of in-flight instructions in internal EX/MEM/WB shadow registers.
- Detects load-use hazards and EX-resolved control redirects, then generates the PC and IF/ID stall/flush controls and the operand forwarding selects.
- Also keeps a saturating load-use stall counter for performance visibility.

Parameters:
REG_ADDR_W, 5, register-address width
CNT_W, 16, stall counter width

Ports:
clk  input  1  pipeline clock, rising edge
rst_n  input  1  asynchronous active-low reset
ID_rs1  input  REG_ADDR_W  source register 1 of the instruction in ID
ID_rs2  input  REG_ADDR_W  source register 2 of the instruction in ID
ID_uses_rs1  input  1  ID instruction reads rs1
ID_uses_rs2  input  1  ID instruction reads rs2
ID_rd  input  REG_ADDR_W  destination register of the ID instruction
ID_Load_Instr  input  1  raw control-unit load flag (pre-mux)
ID_RF_Enable  input  1  raw control-unit RF write enable (pre-mux)
EX_redirect  input  1  taken branch / JAL / JALR resolved in EX this cycle
cu_mux_select  output  1  1 = control mux forces NOP into ID/EX
pc_load_en  output  1  PC register load enable
ifid_load_en  output  1  IF/ID register load enable
ifid_flush  output  1  clear IF/ID to NOP on next edge
fwd_rs1_sel  output  2  00 RF, 01 EX result, 10 MEM result, 11 WB result
fwd_rs2_sel  output  2  same encoding for rs2
stall_count  output  CNT_W  saturating count of load-use stall cycles

Behaviour:
- Shadow slot = {rd, rf_en, load}. Three slots, EX/MEM/WB, all registered on the rising clk edge.
- Per edge:
  - MEM<=EX and WB<=MEM.
  - EX<={ID_rd, ID_RF_Enable, ID_Load_Instr} when cu_mux_select=0; otherwise EX<={0,0,0} (bubble).
- A slot "writes r" iff rf_en=1, rd==r, and r!=0. Register x0 never matches and never forwards.
- load_use (combinational) = EX.load & EX writes rs1 with ID_uses_rs1, OR EX.load & EX writes rs2 with ID_uses_rs2.
- Output priority, all combinational from shadows and inputs:
  1. EX_redirect=1: cu_mux_select=1, ifid_flush=1, pc_load_en=1, ifid_load_en=1. Redirect wins over load_use, which is discarded because the ID instruction is killed.
  2. Else load_use=1: cu_mux_select=1, pc_load_en=0, ifid_load_en=0, ifid_flush=0. The stall lasts exactly 1 cycle: the next cycle EX holds a bubble and the load is in MEM.
  3. Else: cu_mux_select=0, pc_load_en=1, ifid_load_en=1, ifid_flush=0.
- Forwarding, evaluated per operand:
  - First match in order EX (01), MEM (10), WB (11); otherwise 00.
  - Requires the matching uses_rsN=1; otherwise 00.
  - MEM-stage forwarding of a load supplies the RAM read data.
  - Selects are computed even during stall/redirect; the consumer ignores them when bubbled.
- stall_count: +1 on each edge where case 2 is active (not case 1). Holds at 2^CNT_W-1 (saturates, no wrap).
- Reset (rst_n=0, asynchronous, takes effect immediately):
  - All slots cleared and stall_count=0.
  - Outputs forced to cu_mux_select=1, ifid_flush=1, pc_load_en=0, ifid_load_en=0, fwd selects=00.
  - Reset asserted mid-stall aborts the stall. After deassertion the first edge starts from empty shadows.
- Simultaneous events:
  - A load in EX and a redirect in the same cycle: no stall, no count.
  - EX and MEM both write the same register: EX is selected.

Test Plan:
- Load-use: load x5 in ID, then add x6,x5,x1 follows → one cycle with cu_mux_select=1, pc_load_en=0, ifid_load_en=0; next cycle fwd_rs1_sel=10; stall_count 0→1.
- ALU chain: add x3 followed by sub x4,x3,x3 → no stall, fwd_rs1_sel=fwd_rs2_sel=01; two cycles later an instruction reading x3 gets 11.
- x0 destination: load x0 followed by a read of x0 → no stall, selects 00.
- Priority: x7 written in EX and MEM, ID reads x7 → 01. EX_redirect=1 together with a load-use condition → ifid_flush=1, pc_load_en=1, stall_count unchanged.
- Saturation: CNT_W=2, drive 5 load-use stalls → stall_count reaches 3 and stays at 3.
- Reset mid-stall: assert rst_n=0 during a load-use cycle → outputs immediately take reset values, stall_count=0; after release with no hazards → cu_mux_select=0, pc_load_en=1.

Source files
------------

// File: rtl/hazard_forwarding_unit.sv
// Hazard and forwarding control for a 5-stage pipeline: load-use stall, redirect flush,
// operand forwarding selects and a saturating load-use stall counter.
module hazard_forwarding_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] ID_rs1,
  input  logic [REG_ADDR_W-1:0] ID_rs2,
  input  logic                  ID_uses_rs1,
  input  logic                  ID_uses_rs2,
  input  logic [REG_ADDR_W-1:0] ID_rd,
  input  logic                  ID_Load_Instr,
  input  logic                  ID_RF_Enable,
  input  logic                  EX_redirect,
  output logic                  cu_mux_select,
  output logic                  pc_load_en,
  output logic                  ifid_load_en,
  output logic                  ifid_flush,
  output logic [1:0]            fwd_rs1_sel,
  output logic [1:0]            fwd_rs2_sel,
  output logic [CNT_W-1:0]      stall_count
);

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic                  rf_en;
    logic                  load;
  } slot_t;

  slot_t ex_p1, mem_p2, wb_p3;
  slot_t id_slot;
  logic  load_use;
  logic  stall_cycle;

  // x0 is hard-wired to zero, so a write to it is never a real producer.
  function automatic logic writes_reg(input slot_t s, input logic [REG_ADDR_W-1:0] r);
    return s.rf_en && (s.rd == r) && (r != '0);
  endfunction

  function automatic logic [1:0] fwd_select(input logic uses, input logic [REG_ADDR_W-1:0] r,
                                            input slot_t ex, input slot_t mem, input slot_t wb);
    if (!uses)                 return 2'b00;
    if (writes_reg(ex, r))     return 2'b01;
    if (writes_reg(mem, r))    return 2'b10;
    if (writes_reg(wb, r))     return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  assign id_slot = '{rd: ID_rd, rf_en: ID_RF_Enable, load: ID_Load_Instr};

  always_comb begin
    load_use = ex_p1.load &&
               ((ID_uses_rs1 && writes_reg(ex_p1, ID_rs1)) ||
                (ID_uses_rs2 && writes_reg(ex_p1, ID_rs2)));
    // A redirect kills the ID instruction, so its load-use hazard never stalls.
    stall_cycle   = load_use && !EX_redirect;
    cu_mux_select = 1'b0;
    pc_load_en    = 1'b1;
    ifid_load_en  = 1'b1;
    ifid_flush    = 1'b0;
    if (!rst_n) begin
      cu_mux_select = 1'b1;
      ifid_flush    = 1'b1;
      pc_load_en    = 1'b0;
      ifid_load_en  = 1'b0;
    end else if (EX_redirect) begin
      cu_mux_select = 1'b1;
      ifid_flush    = 1'b1;
    end else if (load_use) begin
      cu_mux_select = 1'b1;
      pc_load_en    = 1'b0;
      ifid_load_en  = 1'b0;
    end
    fwd_rs1_sel = rst_n ? fwd_select(ID_uses_rs1, ID_rs1, ex_p1, mem_p2, wb_p3) : 2'b00;
    fwd_rs2_sel = rst_n ? fwd_select(ID_uses_rs2, ID_rs2, ex_p1, mem_p2, wb_p3) : 2'b00;
  end

  // ID -> EX -> MEM -> WB shadow advance; a bubbled ID enters EX as an empty slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_p1       <= '0;
      mem_p2      <= '0;
      wb_p3       <= '0;
      stall_count <= '0;
    end else begin
      ex_p1  <= cu_mux_select ? slot_t'('0) : id_slot;
      mem_p2 <= ex_p1;
      wb_p3  <= mem_p2;
      if (stall_cycle)
        stall_count <= sat_inc(stall_count);
    end
  end

endmodule
